// File: rtl/syncgen_param.sv
// Parametrised video timing generator: h/v counters, sync pulses, visible/blank flags and line/frame strobes.
// Define SYNCGEN_FRAMECNT_EN to add a 16-bit frame counter output (frame_count).
module syncgen_param #(
  parameter int H_VISIBLE = 800,
  parameter int H_FRONT   = 40,
  parameter int H_SYNC    = 128,
  parameter int H_BACK    = 88,
  parameter int V_VISIBLE = 600,
  parameter int V_FRONT   = 1,
  parameter int V_SYNC    = 4,
  parameter int V_BACK    = 23,
  parameter bit HSYNC_POL = 1'b1,
  parameter bit VSYNC_POL = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hsync,
  output logic             vsync,
  output logic             vis,
  output logic             vblank,
  output logic             sol,
  output logic             sof
`ifdef SYNCGEN_FRAMECNT_EN
  ,
  output logic [15:0]      frame_count
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

  logic             h_wrap;
  logic             v_wrap;
  logic [CNT_W-1:0] hcount_nxt;
  logic [CNT_W-1:0] vcount_nxt;
  logic             h_active;
  logic             v_active;
  logic             vis_nxt;
  logic             vblank_nxt;
  logic             sol_nxt;
  logic             sof_nxt;

  // Everything below is decoded from the current (pre-edge) counts, so outputs trail the counters by one ce.
  always_comb begin
    h_wrap     = (hcount == H_LAST);
    v_wrap     = (vcount == V_LAST);
    hcount_nxt = h_wrap ? '0 : hcount + CNT_W'(1);
    vcount_nxt = vcount;
    if (h_wrap) begin
      vcount_nxt = v_wrap ? '0 : vcount + CNT_W'(1);
    end
    h_active   = (hcount >= HS_START) && (hcount < HS_END);
    v_active   = (vcount >= VS_START) && (vcount < VS_END);
    vis_nxt    = (hcount < H_VIS) && (vcount < V_VIS);
    vblank_nxt = (vcount >= V_VIS);
    sol_nxt    = h_wrap;
    sof_nxt    = h_wrap && v_wrap;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcount <= '0;
      vcount <= '0;
      hsync  <= ~HSYNC_POL;
      vsync  <= ~VSYNC_POL;
      vis    <= 1'b0;
      vblank <= 1'b0;
      sol    <= 1'b0;
      sof    <= 1'b0;
    end else if (ce) begin
      hcount <= hcount_nxt;
      vcount <= vcount_nxt;
      hsync  <= ~(h_active ^ HSYNC_POL);
      vsync  <= ~(v_active ^ VSYNC_POL);
      vis    <= vis_nxt;
      vblank <= vblank_nxt;
      sol    <= sol_nxt;
      sof    <= sof_nxt;
    end else begin
      // Strobes must not stretch across idle ce cycles.
      sol <= 1'b0;
      sof <= 1'b0;
    end
  end

`ifdef SYNCGEN_FRAMECNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_count <= '0;
    end else if (ce && sof_nxt) begin
      frame_count <= frame_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_syncgen_param.sv
// Scoreboard bench for syncgen_param at 16x8 timing; a second instance checks inverted sync polarity.
// Frame counter checks are active when SYNCGEN_FRAMECNT_EN is defined.
module tb_syncgen_param;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce  = 1'b0;
  logic [15:0] hcount, vcount, hcount_n, vcount_n;
  logic        hsync, vsync, vis, vblank, sol, sof;
  logic        hsync_n, vsync_n, vis_n, vblank_n, sol_n, sof_n;
`ifdef SYNCGEN_FRAMECNT_EN
  logic [15:0] frame_count, frame_count_n;
`endif

  typedef struct {
    int h; int v;
    bit hs; bit vs; bit vis; bit vb; bit sol; bit sof;
    int fc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  int mh = 0, mv = 0, m_fc = 0;
  bit m_hs, m_vs, m_vis, m_vb, m_sol, m_sof;

  always #5 clk = ~clk;

  syncgen_param #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .ce(ce),
    .hcount(hcount), .vcount(vcount),
    .hsync(hsync), .vsync(vsync), .vis(vis), .vblank(vblank),
    .sol(sol), .sof(sof)
`ifdef SYNCGEN_FRAMECNT_EN
    , .frame_count(frame_count)
`endif
  );

  syncgen_param #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CNT_W(16)
  ) dut_neg (
    .clk(clk), .rst(rst), .ce(ce),
    .hcount(hcount_n), .vcount(vcount_n),
    .hsync(hsync_n), .vsync(vsync_n), .vis(vis_n), .vblank(vblank_n),
    .sol(sol_n), .sof(sof_n)
`ifdef SYNCGEN_FRAMECNT_EN
    , .frame_count(frame_count_n)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Drive one clock of inputs and push what the DUT must show after the following edge.
  task automatic applyStimulus(input bit c, input bit r);
    exp_t e;
    @(negedge clk);
    ce  = c;
    rst = r;
    if (r) begin
      mh = 0; mv = 0; m_fc = 0;
      m_hs = 0; m_vs = 0; m_vis = 0; m_vb = 0; m_sol = 0; m_sof = 0;
    end else if (c) begin
      m_hs  = (mh >= 10 && mh <= 12);
      m_vs  = (mv >= 5 && mv <= 6);
      m_vis = (mh < 8) && (mv < 4);
      m_vb  = (mv >= 4);
      m_sol = (mh == 15);
      m_sof = m_sol && (mv == 7);
      if (m_sof) m_fc = (m_fc + 1) & 32'hFFFF;
      if (mh == 15) begin
        mh = 0;
        mv = (mv == 7) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
    end else begin
      m_sol = 0;
      m_sof = 0;
    end
    e.h = mh; e.v = mv;
    e.hs = m_hs; e.vs = m_vs; e.vis = m_vis; e.vb = m_vb;
    e.sol = m_sol; e.sof = m_sof; e.fc = m_fc;
    sb_q.push_back(e);
  endtask

  always @(posedge clk) begin
    #2;
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      checkOutput("hcount", 32'(hcount), mon_e.h);
      checkOutput("vcount", 32'(vcount), mon_e.v);
      checkOutput("hsync",  32'(hsync),  32'(mon_e.hs));
      checkOutput("vsync",  32'(vsync),  32'(mon_e.vs));
      checkOutput("vis",    32'(vis),    32'(mon_e.vis));
      checkOutput("vblank", 32'(vblank), 32'(mon_e.vb));
      checkOutput("sol",    32'(sol),    32'(mon_e.sol));
      checkOutput("sof",    32'(sof),    32'(mon_e.sof));
      checkOutput("hsync_neg", 32'(hsync_n), 32'(!mon_e.hs));
      checkOutput("vsync_neg", 32'(vsync_n), 32'(!mon_e.vs));
      checkOutput("hcount_neg", 32'(hcount_n), mon_e.h);
      checkOutput("sol_neg", 32'(sol_n), 32'(mon_e.sol));
`ifdef SYNCGEN_FRAMECNT_EN
      checkOutput("frame_count", 32'(frame_count), mon_e.fc);
`endif
    end
  end

  initial begin
    int tries;
    $display("[TB] start");
    repeat (2) applyStimulus(1'b0, 1'b1);

    repeat (300) applyStimulus(1'b1, 1'b0);

    for (int i = 0; i < 80; i++) applyStimulus(i[0] == 1'b0, 1'b0);

    tries = 0;
    while (!(mh == 9 && mv == 5) && tries < 200) begin
      applyStimulus(1'b1, 1'b0);
      tries++;
    end
    if (tries >= 200) checkOutput("reach_h9_v5", 32'(tries), 32'd0);
    applyStimulus(1'b1, 1'b1);
    repeat (150) applyStimulus(1'b1, 1'b0);

    applyStimulus(1'b1, 1'b1);
    repeat (384) applyStimulus(1'b1, 1'b0);
    @(posedge clk);
    #3;
`ifdef SYNCGEN_FRAMECNT_EN
    checkOutput("frame_count_after_3_frames", 32'(frame_count), 32'd3);
`endif
    checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
